// File: rtl/mtl_sprite_display.sv
// MTL panel timing generator and sprite compositor.
// Counters produce HD/VD and frame pulses; N_SPR sprites (square or disc)
// are drawn over an SDRAM-streamed background, with per-frame overlap flags.
// The pixel for x_cnt is computed one cycle early (x_cnt-1) and registered,
// so the colour lands exactly on x_cnt. SDRAM data requested at x_cnt-2
// arrives during that compute cycle.
module mtl_sprite_display #(
  parameter int          H_LINE   = 1056,
  parameter int          V_LINE   = 525,
  parameter int          H_BLANK  = 46,
  parameter int          H_FRONT  = 210,
  parameter int          V_BLANK  = 23,
  parameter int          V_FRONT  = 22,
  parameter int          N_SPR    = 8,
  parameter int          HALF     = 20,
  parameter logic [23:0] LOAD_RGB = 24'h0000FF
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iLoading,
  input  logic [10*N_SPR-1:0]   iX,
  input  logic [9*N_SPR-1:0]    iY,
  input  logic [N_SPR-1:0]      iEN,
  input  logic [N_SPR-1:0]      iSHAPE,
  input  logic [24*N_SPR-1:0]   iCOLOR,
  input  logic [31:0]           iREAD_DATA,
  output logic                  oREAD_EN,
  output logic                  oNew_Frame,
  output logic                  oEnd_Frame,
  output logic                  oHD,
  output logic                  oVD,
  output logic [7:0]            oLCD_R,
  output logic [7:0]            oLCD_G,
  output logic [7:0]            oLCD_B,
  output logic [N_SPR-1:0]      oCollide
);

  localparam int H_ACT = H_LINE - H_BLANK - H_FRONT;
  localparam int V_ACT = V_LINE - V_BLANK - V_FRONT;
  localparam int XW    = $clog2(H_LINE);
  localparam int YW    = $clog2(V_LINE);

  localparam logic [XW-1:0] X_LAST = XW'(H_LINE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINE - 1);
  localparam logic [XW-1:0] X_EF   = XW'(H_LINE - H_FRONT);
  localparam logic [YW-1:0] Y_EF   = YW'(V_LINE - V_FRONT - 1);
  localparam logic [XW-1:0] X_RD0  = XW'(H_BLANK - 2);
  localparam logic [XW-1:0] X_RD1  = XW'(H_BLANK + H_ACT - 3);
  localparam logic [XW-1:0] X_PX0  = XW'(H_BLANK - 1);
  localparam logic [XW-1:0] X_PX1  = XW'(H_BLANK + H_ACT - 2);
  localparam logic [YW-1:0] Y_A0   = YW'(V_BLANK);
  localparam logic [YW-1:0] Y_A1   = YW'(V_BLANK + V_ACT - 1);
  localparam logic [11:0]   HALF_A = 12'(HALF);
  localparam logic [23:0]   HALF_SQ = 24'(HALF * HALF);

  typedef enum logic [1:0] {WHITE, LOADING, SHOW} state_t;

  // state is the FSM observation point for checkers
  state_t              state, state_nxt;
  logic [XW-1:0]       x_cnt;
  logic [YW-1:0]       y_cnt;
  logic                new_frame, y_active, pix_on, any_hit, multi;
  logic signed [11:0]  px, py;
  logic [N_SPR-1:0]    hit, acc;
  logic [23:0]         spr_col, pix_nxt;
  logic [9:0]          sh_x   [N_SPR];
  logic [8:0]          sh_y   [N_SPR];
  logic [23:0]         sh_col [N_SPR];
  logic [N_SPR-1:0]    sh_en, sh_shape;
  logic                unused_rd_hi;

  assign unused_rd_hi = ^iREAD_DATA[31:24];

  // Line/frame counters
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == X_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
    end else begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  assign new_frame  = (x_cnt == '0) && (y_cnt == '0) && iRST_n;
  assign y_active   = (y_cnt >= Y_A0) && (y_cnt <= Y_A1);
  assign pix_on     = y_active && (x_cnt >= X_PX0) && (x_cnt <= X_PX1);
  assign oHD        = (x_cnt != '0);
  assign oVD        = (y_cnt != '0);
  assign oNew_Frame = new_frame;
  assign oEnd_Frame = (x_cnt == X_EF) && (y_cnt == Y_EF);
  assign oREAD_EN   = (state == SHOW) && y_active && (x_cnt >= X_RD0) && (x_cnt <= X_RD1);

  // Coordinates of the pixel that will be shown on the next clock
  assign px = $signed(12'(x_cnt) - 12'(H_BLANK - 1));
  assign py = $signed(12'(y_cnt) - 12'(V_BLANK));

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= WHITE;
    else         state <= state_nxt;
  end

  // FSM next state: loading moves on at once, leaving it waits for a frame start
  always_comb begin
    state_nxt = state;
    case (state)
      WHITE:   if (iLoading) state_nxt = LOADING;
      LOADING: if (new_frame && !iLoading) state_nxt = SHOW;
      SHOW:    if (new_frame && iLoading) state_nxt = LOADING;
      default: state_nxt = WHITE;
    endcase
  end

  // Shadow sprite attributes, captured only at frame start
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sh_en    <= '0;
      sh_shape <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_col[i] <= '0;
      end
    end else if (new_frame) begin
      sh_en    <= iEN;
      sh_shape <= iSHAPE;
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i]   <= iX[10*i +: 10];
        sh_y[i]   <= iY[9*i +: 9];
        sh_col[i] <= iCOLOR[24*i +: 24];
      end
    end
  end

  // Per-sprite hit test; no wrap, so off-screen parts simply never match
  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    logic signed [11:0] dx, dy;
    logic [11:0]        adx, ady;
    logic [23:0]        d2;
    assign dx  = px - $signed({2'b00, sh_x[g]});
    assign dy  = py - $signed({3'b000, sh_y[g]});
    assign adx = dx[11] ? -dx : dx;
    assign ady = dy[11] ? -dy : dy;
    assign d2  = {12'd0, adx} * {12'd0, adx} + {12'd0, ady} * {12'd0, ady};
    assign hit[g] = sh_en[g] && (sh_shape[g] ? (d2 < HALF_SQ)
                                             : ((adx < HALF_A) && (ady < HALF_A)));
  end

  assign any_hit = |hit;
  assign multi   = |(hit & (hit - 1'b1));

  // Priority mux: lowest sprite index wins
  always_comb begin
    spr_col = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) spr_col = sh_col[i];
    end
  end

  // Next pixel colour by display mode
  always_comb begin
    pix_nxt = '0;
    if (pix_on) begin
      case (state)
        WHITE:   pix_nxt = 24'hFFFFFF;
        LOADING: pix_nxt = LOAD_RGB;
        SHOW:    pix_nxt = any_hit ? spr_col : iREAD_DATA[23:0];
        default: pix_nxt = '0;
      endcase
    end
  end

  // Registered colour outputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) {oLCD_R, oLCD_G, oLCD_B} <= '0;
    else         {oLCD_R, oLCD_G, oLCD_B} <= pix_nxt;
  end

  // Sticky overlap accumulator, published and cleared at frame start
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      acc      <= '0;
      oCollide <= '0;
    end else if (new_frame) begin
      oCollide <= acc;
      acc      <= '0;
    end else if ((state == SHOW) && pix_on && multi) begin
      acc <= acc | hit;
    end
  end

endmodule

// File: tb/tb_mtl_sprite_display.sv
// Bench for mtl_sprite_display on a shrunken panel geometry.
// A reference model tracks timing, mode and sprite shadows, pushes the
// expected colour of each active pixel into exp_q, and a negedge monitor
// pops and compares. Per-frame totals and spot pixels go through check_val.
module tb_mtl_sprite_display;
  localparam int H_LINE = 64, H_BLANK = 6, H_FRONT = 8;
  localparam int V_LINE = 40, V_BLANK = 3, V_FRONT = 3;
  localparam int N = 4, HALF = 4;
  localparam int H_ACT = H_LINE - H_BLANK - H_FRONT;
  localparam int V_ACT = V_LINE - V_BLANK - V_FRONT;
  localparam int FULL_RD = H_ACT * V_ACT;
  localparam logic [23:0] LOAD_RGB = 24'h0000FF;
  localparam logic [23:0] RED = 24'hFF0000, GREEN = 24'h00FF00, YELLOW = 24'hFFFF00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              loading = 1'b0;
  logic [10*N-1:0]   spr_x = '0;
  logic [9*N-1:0]    spr_y = '0;
  logic [N-1:0]      spr_en = '0, spr_shape = '0;
  logic [24*N-1:0]   spr_col = '0;
  logic [31:0]       rd_data = '0;
  logic              rd_en, new_frame, end_frame, hd, vd;
  logic [7:0]        lcd_r, lcd_g, lcd_b;
  logic [N-1:0]      collide;

  mtl_sprite_display #(
    .H_LINE(H_LINE), .V_LINE(V_LINE), .H_BLANK(H_BLANK), .H_FRONT(H_FRONT),
    .V_BLANK(V_BLANK), .V_FRONT(V_FRONT), .N_SPR(N), .HALF(HALF), .LOAD_RGB(LOAD_RGB)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iLoading(loading),
    .iX(spr_x), .iY(spr_y), .iEN(spr_en), .iSHAPE(spr_shape), .iCOLOR(spr_col),
    .iREAD_DATA(rd_data), .oREAD_EN(rd_en), .oNew_Frame(new_frame), .oEnd_Frame(end_frame),
    .oHD(hd), .oVD(vd), .oLCD_R(lcd_r), .oLCD_G(lcd_g), .oLCD_B(lcd_b), .oCollide(collide)
  );

  // ---------------- checker ----------------
  int vectors = 0, miscompares = 0;
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int tx = 0, ty = 0, mode = 0;          // mode 0 white, 1 loading, 2 show
  int m_x[N], m_y[N];
  logic [N-1:0] m_en = '0, m_sh = '0, m_col = '0, m_acc = '0;
  logic [23:0]  m_c[N];
  logic         rd_seen = 1'b0;
  logic [23:0]  exp_q[$];
  logic [23:0]  cap    [V_ACT][H_ACT];
  logic [23:0]  bg_cap [V_ACT][H_ACT];

  function automatic logic [23:0] model_pix(input int px, input int py, input logic [23:0] bg,
                                            output logic [N-1:0] hits);
    logic [23:0] c;
    int dx, dy;
    bit h;
    c = bg;
    hits = '0;
    for (int i = N - 1; i >= 0; i--) begin
      dx = px - m_x[i];
      dy = py - m_y[i];
      h = m_sh[i] ? (dx*dx + dy*dy < HALF*HALF)
                  : (dx > -HALF && dx < HALF && dy > -HALF && dy < HALF);
      if (m_en[i] && h) begin
        hits[i] = 1'b1;
        c = m_c[i];
      end
    end
    return c;
  endfunction

  // Model step just after each rising edge; also drives background data
  initial begin
    logic [23:0] bg, e;
    logic [N-1:0] hits;
    int nx, px, py;
    bit nf;
    forever begin
      @(posedge clk); #1;
      rd_data = $urandom;
      if (!rst_n) begin
        tx = 0; ty = 0; mode = 0;
        m_en = '0; m_sh = '0; m_col = '0; m_acc = '0;
        for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_c[i] = '0; end
        exp_q.delete();
      end else begin
        nf = (tx == 0 && ty == 0);
        if (nf) begin
          m_en = spr_en; m_sh = spr_shape;
          for (int i = 0; i < N; i++) begin
            m_x[i] = int'(spr_x[10*i +: 10]);
            m_y[i] = int'(spr_y[9*i +: 9]);
            m_c[i] = spr_col[24*i +: 24];
          end
          m_col = m_acc; m_acc = '0;
        end
        case (mode)
          0: if (loading) mode = 1;
          1: if (nf && !loading) mode = 2;
          default: if (nf && loading) mode = 1;
        endcase
        if (tx == H_LINE - 1) begin
          tx = 0;
          ty = (ty == V_LINE - 1) ? 0 : ty + 1;
        end else tx = tx + 1;
        bg = rd_seen ? rd_data[23:0] : ~rd_data[23:0];
        nx = tx + 1;
        if (ty >= V_BLANK && ty < V_BLANK + V_ACT && nx >= H_BLANK && nx < H_BLANK + H_ACT) begin
          px = nx - H_BLANK;
          py = ty - V_BLANK;
          bg_cap[py][px] = bg;
          if (mode == 0) e = 24'hFFFFFF;
          else if (mode == 1) e = LOAD_RGB;
          else begin
            e = model_pix(px, py, bg, hits);
            if ($countones(hits) >= 2) m_acc = m_acc | hits;
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int c_hd, c_vd, c_nf, c_ef, c_rd;
  int l_hd, l_vd, l_nf, l_ef, l_rd;
  int frame_no = 0, sync_err = 0, pix_err = 0;

  initial begin
    logic [23:0] got, e;
    bit exp_rd;
    c_hd = 0; c_vd = 0; c_nf = 0; c_ef = 0; c_rd = 0;
    l_hd = 0; l_vd = 0; l_nf = 0; l_ef = 0; l_rd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_seen = 1'b0;
        c_hd = 0; c_vd = 0; c_nf = 0; c_ef = 0; c_rd = 0;
      end else begin
        if (tx == 0 && ty == 0) begin
          l_hd = c_hd; l_vd = c_vd; l_nf = c_nf; l_ef = c_ef; l_rd = c_rd;
          c_hd = 0; c_vd = 0; c_nf = 0; c_ef = 0; c_rd = 0;
          frame_no++;
        end
        rd_seen = rd_en;
        if (!hd) c_hd++;
        if (!vd) c_vd++;
        if (new_frame) c_nf++;
        if (end_frame) c_ef++;
        if (rd_en) c_rd++;
        exp_rd = (mode == 2) && ty >= V_BLANK && ty < V_BLANK + V_ACT &&
                 tx >= H_BLANK - 2 && tx <= H_BLANK + H_ACT - 3;
        if (hd !== (tx != 0)) sync_err++;
        if (vd !== (ty != 0)) sync_err++;
        if (new_frame !== (tx == 0 && ty == 0)) sync_err++;
        if (end_frame !== (tx == H_LINE - H_FRONT && ty == V_LINE - V_FRONT - 1)) sync_err++;
        if (rd_en !== exp_rd) sync_err++;
        if (collide !== m_col) sync_err++;
        got = {lcd_r, lcd_g, lcd_b};
        if (ty >= V_BLANK && ty < V_BLANK + V_ACT && tx >= H_BLANK && tx < H_BLANK + H_ACT) begin
          cap[ty - V_BLANK][tx - H_BLANK] = got;
          if (exp_q.size() == 0) pix_err++;
          else begin
            e = exp_q.pop_front();
            if (got !== e) pix_err++;
          end
        end else if (got !== 24'h0) pix_err++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_spr(input int i, input int x, input int y, input bit en,
                         input bit shape, input logic [23:0] c);
    spr_x[10*i +: 10]   = 10'(x);
    spr_y[9*i +: 9]     = 9'(y);
    spr_en[i]           = en;
    spr_shape[i]        = shape;
    spr_col[24*i +: 24] = c;
  endtask

  task automatic wait_frame();
    int f0, k;
    f0 = frame_no;
    k = 0;
    while (frame_no == f0 && k < 3 * H_LINE * V_LINE) begin
      @(negedge clk); #2;
      k++;
    end
    check_val("frame_timeout", (frame_no == f0) ? 1 : 0, 0);
  endtask

  task automatic wait_pos(input int x, input int y);
    int k;
    k = 0;
    while (!(tx == x && ty == y) && k < 3 * H_LINE * V_LINE) begin
      @(negedge clk); #2;
      k++;
    end
    check_val("pos_timeout", (tx == x && ty == y) ? 0 : 1, 0);
  endtask

  int prev_sync = 0, prev_pix = 0;
  task automatic check_frame(input string tag, input int exp_rd);
    check_val({tag, " hd_low"}, l_hd, V_LINE);
    check_val({tag, " vd_low"}, l_vd, H_LINE);
    check_val({tag, " new_frame"}, l_nf, 1);
    check_val({tag, " end_frame"}, l_ef, 1);
    check_val({tag, " read_en"}, l_rd, exp_rd);
    check_val({tag, " sync_err"}, sync_err - prev_sync, 0);
    check_val({tag, " pix_err"}, pix_err - prev_pix, 0);
    prev_sync = sync_err;
    prev_pix = pix_err;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " rgb"}, {lcd_r, lcd_g, lcd_b}, 0);
    check_val({tag, " hd_vd"}, {hd, vd}, 0);
    check_val({tag, " pulses"}, {new_frame, end_frame, rd_en}, 0);
    check_val({tag, " collide"}, collide, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); #1 rst_n = 1'b1;

    // white after reset
    wait_frame();
    wait_frame();
    check_frame("white", 0);
    check_val("white px", cap[0][0], 24'hFFFFFF);

    // raise loading mid-frame: blue from the next clock
    wait_pos(20, V_BLANK + 10);
    loading = 1'b1;
    wait_frame();
    check_frame("white_to_load", 0);
    check_val("pre_load px", cap[0][0], 24'hFFFFFF);
    check_val("load px", cap[V_ACT-1][H_ACT-1], LOAD_RGB);

    // configure sprites and drop loading mid-frame
    wait_pos(10, V_BLANK + 5);
    set_spr(0, 0, 0, 1, 0, RED);
    set_spr(2, 30, 20, 1, 1, YELLOW);
    loading = 1'b0;
    wait_frame();
    check_frame("load", 0);
    check_val("load px2", cap[20][20], LOAD_RGB);

    // frame A: show; move things mid-frame (must not affect this frame)
    wait_pos(0, V_BLANK + 5);
    check_val("collide_a", collide, 0);
    wait_pos(10, V_BLANK + 10);
    set_spr(0, 10, 10, 1, 0, RED);
    set_spr(1, 13, 10, 1, 0, GREEN);
    set_spr(2, 40, 20, 1, 1, YELLOW);
    wait_frame();
    check_frame("show_a", FULL_RD);
    check_val("clip origin", cap[0][0], RED);
    check_val("clip corner", cap[3][3], RED);
    check_val("clip edge x", cap[0][4], bg_cap[0][4]);
    check_val("no wrap x", cap[0][H_ACT-1], bg_cap[0][H_ACT-1]);
    check_val("no wrap y", cap[V_ACT-1][0], bg_cap[V_ACT-1][0]);
    check_val("disc in", cap[22][33], YELLOW);
    check_val("disc edge", cap[20][34], bg_cap[20][34]);
    check_val("disc out", cap[24][32], bg_cap[24][32]);

    // frame B: new positions, priority
    wait_frame();
    check_frame("show_b", FULL_RD);
    check_val("overlap red", cap[10][12], RED);
    check_val("spr1 green", cap[10][15], GREEN);
    check_val("spr1 right", cap[10][17], bg_cap[10][17]);
    check_val("spr0 left", cap[10][6], bg_cap[10][6]);
    check_val("disc moved", cap[22][43], YELLOW);
    check_val("disc old", cap[22][33], bg_cap[22][33]);
    @(negedge clk); @(negedge clk);
    check_val("collide_b", collide, 4'b0011);

    // frame C: disable sprite1 mid-frame
    wait_pos(0, V_BLANK + 20);
    set_spr(1, 13, 10, 0, 0, GREEN);
    wait_frame();
    check_frame("show_c", FULL_RD);
    check_val("spr1 kept", cap[10][15], GREEN);
    @(negedge clk); @(negedge clk);
    check_val("collide_c", collide, 4'b0011);

    // frame D: sprite1 gone, no overlaps
    wait_pos(0, V_BLANK + 20);
    loading = 1'b0;
    wait_frame();
    check_frame("show_d", FULL_RD);
    check_val("spr1 off", cap[10][15], bg_cap[10][15]);
    @(negedge clk); @(negedge clk);
    check_val("collide_d", collide, 4'b0000);

    // frame E: request a reload mid-frame
    wait_pos(30, V_BLANK + 15);
    loading = 1'b1;
    wait_frame();
    check_frame("show_e", FULL_RD);
    wait_frame();
    check_frame("reload", 0);
    check_val("reload px", cap[0][0], LOAD_RGB);

    // reset in the middle of an active line
    wait_pos(H_BLANK + 10, V_BLANK + 2);
    rst_n = 1'b0;
    #1 check_reset_outputs("midline_rst");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_frame();
    prev_sync = sync_err;
    prev_pix = pix_err;
    wait_frame();
    check_frame("after_rst", 0);
    check_val("after_rst px", cap[5][5], LOAD_RGB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mtl_sprite_display.md
Name: mtl_sprite_display

Overview:
- Parametrised LCD timing generator and compositor for the MTL panel. Replaces the fixed five-square display with N_SPR sprites, each with its own enable, colour and shape (square or disc).
- Sprite overlays sit on an SDRAM-streamed background.
- Sprite attributes update only at frame boundaries.
- Reports per-frame sprite overlaps for game logic.

Parameters:
H_LINE, 1056, total clocks per line
V_LINE, 525, total lines per frame
H_BLANK, 46, HSYNC + back porch clocks
H_FRONT, 210, horizontal front porch clocks
V_BLANK, 23, VSYNC + back porch lines
V_FRONT, 22, vertical front porch lines
N_SPR, 8, number of sprites (1..16)
HALF, 20, sprite half-size / disc radius in pixels
LOAD_RGB, 24'h0000FF, fill colour while loading

Ports:
iCLK  in  1  pixel clock
iRST_n  in  1  reset
iLoading  in  1  host loading flag
iX  in  10*N_SPR  sprite centre x (active-area pixels), sprite i at [10i+9:10i]
iY  in  9*N_SPR  sprite centre y, sprite i at [9i+8:9i]
iEN  in  N_SPR  sprite enable
iSHAPE  in  N_SPR  0 = square, 1 = disc
iCOLOR  in  24*N_SPR  sprite RGB, R in the top byte
iREAD_DATA  in  32  background pixel from SDRAM, RGB in [23:0]
oREAD_EN  out  1  SDRAM read request
oNew_Frame  out  1  frame-start pulse
oEnd_Frame  out  1  frame-end pulse
oHD  out  1  horizontal sync, active low
oVD  out  1  vertical sync, active low
oLCD_R, oLCD_G, oLCD_B  out  8 each  pixel colour
oCollide  out  N_SPR  sprites that overlapped another sprite in the previous frame

Behaviour:
- Reset: iRST_n, asynchronous, active-low; clock iCLK. While low, all counters and registered outputs are 0, state = WHITE, and the shadow registers are cleared (no sprites enabled).

Timing counters
- x_cnt counts 0..H_LINE-1 and wraps. y_cnt increments on the x wrap and wraps at V_LINE-1.
- oHD is low only while x_cnt == 0. oVD is low for the whole of line y_cnt == 0.
- oNew_Frame = (x_cnt == 0 && y_cnt == 0 && iRST_n).
- oEnd_Frame = (x_cnt == H_LINE-H_FRONT && y_cnt == V_LINE-V_FRONT-1).

Active area
- Active pixel (px, py), px = 0..799, py = 0..479, occupies x_cnt = H_BLANK+px, y_cnt = V_BLANK+py.
- oLCD_* carries that pixel's colour in exactly that cycle. All three colour outputs are registered.
- Outside the active area, oLCD_* = 0.

SDRAM read
- oREAD_EN is asserted at x_cnt = H_BLANK+px-2 for every active pixel, and only in state SHOW: 800 pulses per active line.
- iREAD_DATA is valid one cycle after the corresponding request.

State machine (WHITE, LOADING, SHOW)
- WHITE: fills the active area with FFFFFF. iLoading=1 moves to LOADING on the next clock.
- LOADING: fills with LOAD_RGB. iLoading=0 at oNew_Frame moves to SHOW.
- SHOW: background comes from iREAD_DATA, with sprites on top. iLoading=1 at oNew_Frame moves to LOADING (re-load supported).

Sprite shadow registers
- iX, iY, iEN, iSHAPE and iCOLOR are captured into shadow registers in the oNew_Frame cycle.
- Input changes mid-frame never affect the current frame.

Hit test (signed 12-bit)
- dx = px - X_i, dy = py - Y_i.
- Square: |dx| < HALF && |dy| < HALF.
- Disc: dx*dx + dy*dy < HALF*HALF.
- There is no modulo wrap: a sprite near the edge is clipped.

Composition
- Among enabled sprites that hit, the lowest index wins. Otherwise the background is shown.

Collision
- If two or more enabled sprites hit the same active pixel, their bits set in a sticky accumulator.
- At oNew_Frame: oCollide <= accumulator, then the accumulator clears. oCollide holds its value for the whole frame.
- Collisions are evaluated only in SHOW.

Reset and pipelining
- Reset mid-frame: counters restart at 0,0 and output stays black until the first active pixel.
- Pipeline latency is absorbed internally, so the alignment above is exact.

Test Plan:
- Reset release, defaults -> oHD low 1 cycle per 1056. oVD low 1056 cycles per 554400. First active pixel at x_cnt=46, y_cnt=23.
- Loading sequence -> iLoading 0: white, no oREAD_EN. Raise iLoading: blue 0000FF, still no oREAD_EN. Drop iLoading mid-frame: SHOW from the next frame. 800x480 oREAD_EN pulses per frame, and pixel px shows iREAD_DATA from the request 2 cycles earlier.
- Edge clipping, sprite0 square at (0,0), HALF=20 -> px, py 0..19 coloured. px 780..799 and py 460..479 untouched (no wrap).
- Priority and collision -> sprite0 red at (100,100), sprite1 green at (110,100): overlap pixels red, sprite1-only pixels green. Next frame oCollide = 8'h03. Disable sprite1 -> following frame oCollide = 0.
- Disc boundary, sprite2 disc at (400,240) -> pixel (414,254) coloured (392 < 400). Pixel (415,254) shows background (421 >= 400).
- Frame-synchronous update -> change iX mid-frame: the current frame is unchanged, and the new position appears from the next oNew_Frame. Reset asserted mid-line -> all outputs 0 immediately.
